// File: rtl/rw_context_arbiter.sv
// Shares one combinational ReWire step device among N_REQ requesters, keeping a
// private resumption tag and halted flag per requester so each sees its own context.
module rw_ctx_slot #(
  parameter int                 TAG_W     = 1,
  parameter logic [TAG_W-1:0]   TAG_RESET = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_restart,
  input  logic             i_defer,
  input  logic             i_exec,
  input  logic [TAG_W-1:0] i_tag_next,
  input  logic             i_cont,
  input  logic             i_exit,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_halted
);
  logic r_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tag    <= TAG_RESET;
      o_halted <= 1'b0;
      r_pend   <= 1'b0;
    end else if (i_exit && (r_pend || i_restart)) begin
      o_tag    <= TAG_RESET;
      o_halted <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (i_exec) begin
        o_tag <= i_tag_next;
        if (!i_cont) o_halted <= 1'b1;
      end
      // A restart aimed at the context in flight waits until its response retires.
      if (i_restart) begin
        if (i_defer) r_pend <= 1'b1;
        else begin
          o_tag    <= TAG_RESET;
          o_halted <= 1'b0;
        end
      end
    end
  end
endmodule

module rw_context_arbiter #(
  parameter int               N_REQ     = 4,
  parameter int               IN_W      = 1,
  parameter int               OUT_W     = 1,
  parameter int               TAG_W     = 1,
  parameter logic [TAG_W-1:0] TAG_RESET = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*IN_W-1:0] i_req_in,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [OUT_W-1:0]      o_rsp_out,
  input  logic [N_REQ-1:0]      i_rsp_ready,
  input  logic [N_REQ-1:0]      i_restart,
  output logic [N_REQ-1:0]      o_halted,
  output logic [IN_W-1:0]       o_dev_in,
  output logic [TAG_W-1:0]      o_dev_tag,
  input  logic [OUT_W-1:0]      i_dev_out,
  input  logic [TAG_W-1:0]      i_dev_tag_next,
  input  logic                  i_dev_continue
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                        r_state;
  logic [PW-1:0]                 r_rr, r_gnt;
  logic [IN_W-1:0]               r_dev_in;
  logic [TAG_W-1:0]              r_dev_tag;
  logic [OUT_W-1:0]              r_rsp_out;
  logic [N_REQ-1:0]              r_rsp_valid;
  logic [N_REQ-1:0]              w_elig, w_halted, w_ready;
  logic [N_REQ-1:0][TAG_W-1:0]   w_tag;
  logic                          w_any, w_exit;
  logic [PW-1:0]                 w_idx;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'((v >= N_REQ) ? v - N_REQ : v);
  endfunction

  assign w_elig = i_req_valid & ~w_halted;
  assign w_exit = (r_state == S_RESP) && i_rsp_ready[r_gnt];

  // Scan downward so the lowest offset from r_rr is the one left standing.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_elig[wrap(int'(r_rr) + k)]) begin
        w_any = 1'b1;
        w_idx = wrap(int'(r_rr) + k);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_any && !i_rst) w_ready[w_idx] = 1'b1;
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    logic w_act;
    assign w_act = (r_gnt == PW'(i));
    rw_ctx_slot #(.TAG_W(TAG_W), .TAG_RESET(TAG_RESET)) u_slot (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_restart  (i_restart[i]),
      .i_defer    ((r_state == S_IDLE) ? w_ready[i] : w_act),
      .i_exec     ((r_state == S_EXEC) && w_act),
      .i_tag_next (i_dev_tag_next),
      .i_cont     (i_dev_continue),
      .i_exit     (w_exit && w_act),
      .o_tag      (w_tag[i]),
      .o_halted   (w_halted[i])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_gnt       <= '0;
      r_dev_in    <= '0;
      r_dev_tag   <= TAG_RESET;
      r_rsp_out   <= '0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt     <= w_idx;
          r_dev_in  <= i_req_in[w_idx*IN_W +: IN_W];
          r_dev_tag <= w_tag[w_idx];
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_rsp_out   <= i_dev_out;
          r_rsp_valid <= N_REQ'(1) << r_gnt;
          r_state     <= S_RESP;
        end
        S_RESP: if (w_exit) begin
          r_rsp_valid <= '0;
          r_rr        <= (r_gnt == PW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = w_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_out   = r_rsp_out;
  assign o_halted    = w_halted;
  assign o_dev_in    = r_dev_in;
  assign o_dev_tag   = r_dev_tag;
endmodule

// File: doc/rw_context_arbiter.md
Name: rw_context_arbiter

Overview:
- Time-multiplexes one compiled ReWire step device among N_REQ independent requesters.
- The device is combinational. It takes an input value and a current resumption tag, and returns an output, a next tag and a continue bit.
- The arbiter keeps a per-requester resumption-tag table, so each requester sees a private instance of the device's state machine.
- It sits between the requester ports and a single shared device instance in the generated top level.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- IN_W, 1, device input width
- OUT_W, 1, device output width
- TAG_W, 1, device resumption-tag width
- TAG_RESET, 0, tag value loaded at reset and on restart

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request present, one bit per requester
- req_in  in  N_REQ*IN_W  request data; requester i occupies slice [i*IN_W +: IN_W]
- req_ready  out  N_REQ  one-hot accept pulse
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_out  out  OUT_W  response data, qualified by rsp_valid
- rsp_ready  in  N_REQ  response accept, one bit per requester
- restart  in  N_REQ  pulse: clear halted flag and reset the tag
- halted  out  N_REQ  requester's device context has terminated
- dev_in  out  IN_W  to shared device
- dev_tag  out  TAG_W  to shared device
- dev_out  in  OUT_W  from shared device
- dev_tag_next  in  TAG_W  from shared device
- dev_continue  in  1  from shared device

Behaviour:
- Reset (asynchronous):
  - state=IDLE, rr_ptr=0, every tag entry=TAG_RESET, halted=0.
  - req_ready=0, rsp_valid=0, rsp_out=0, dev_in=0, dev_tag=TAG_RESET.
  - Reset asserted mid-operation abandons the in-flight request; no response is issued.
- Eligibility: requester i is eligible when req_valid[i]=1 and halted[i]=0.
- IDLE:
  - If any requester is eligible, grant the first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - In the same cycle, assert req_ready[g] combinationally; no other requester's ready bit is set.
  - Register g and req_in slice g, then go to EXEC.
  - If no requester is eligible, stay in IDLE with all req_ready=0.
- EXEC (one cycle):
  - dev_in = latched input; dev_tag = tag[g].
  - At the clock edge: tag[g] <= dev_tag_next; rsp_out register <= dev_out.
  - If dev_continue=0, set halted[g]=1 and leave tag[g]=dev_tag_next.
  - Go to RESP.
- RESP:
  - rsp_valid[g]=1 (registered) and rsp_out are held stable until rsp_ready[g]=1.
  - On the handshake: rsp_valid <= 0, rr_ptr <= (g+1) mod N_REQ, go to IDLE.
  - rsp_ready bits for other indices are ignored.
- Latency: accept in cycle t, rsp_valid first high in cycle t+2. Minimum spacing between accepts is 3 cycles.
- dev_in and dev_tag are don't-care outside EXEC, but are held at their last driven values.
- restart[i] when i is not the active index: in the next cycle tag[i]=TAG_RESET and halted[i]=0.
- restart[g] while g is in EXEC or RESP: held pending and applied in the cycle RESP exits. It overrides the EXEC tag and halted updates.
- restart[i] asserted in the same IDLE cycle in which i is granted: the grant proceeds using the old tag, and the restart is treated as pending.
- A halted requester with req_valid=1 never receives req_ready; the request waits for a restart.
- No combinational path from rsp_ready to req_ready.

Test Plan:
- Reset, then req_valid=4'b0001, req_in[0]=1, device acting as identity with tag_next=in and continue=1 -> req_ready[0] pulses at t; rsp_valid[0] at t+2 with rsp_out=1; tag[0]=1.
- All four requesters valid continuously, rsp_ready tied high -> grant order 0,1,2,3,0; accepts exactly 3 cycles apart.
- Requester 2 stalls rsp_ready for 5 cycles -> rsp_valid[2] and rsp_out held stable; no new req_ready during the stall.
- Device returns continue=0 for requester 1 -> halted[1]=1; later req_valid[1] is never granted; restart[1] -> halted[1]=0, tag[1]=TAG_RESET, next request is granted.
- Two requesters with distinct tag histories, interleaved -> each response matches a golden single-context ReWire model run per requester.
- rst pulsed during RESP -> rsp_valid drops immediately; all tags=TAG_RESET; the next request is granted from index 0.
